// File: rtl/par_arbiter_m2s.sv
// AR-channel arbiter for one slave port: round-robin grant among the masters,
// forwards the winner's ARVALID/payload and drives the one-hot select that
// routes ARREADY back to the winner.
module par_arbiter_m2s #(
    parameter int MasterCount  = 2,
    parameter int PayloadWidth = 49
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [MasterCount-1:0]              ARVALID_in,
    input  logic [MasterCount*PayloadWidth-1:0] ARpayload_in,
    input  logic                                ARREADY_in,
    output logic                                ARVALID_out,
    output logic [PayloadWidth-1:0]             ARpayload_out,
    output logic [MasterCount-1:0]              ARsel_out
);

    localparam int IDX_W = (MasterCount > 1) ? $clog2(MasterCount) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                   state_r;
    state_e                   state_nxt_s;
    logic [MasterCount-1:0]   grant_r;
    logic [MasterCount-1:0]   grant_nxt_s;
    logic [MasterCount-1:0]   ptr_r;
    logic [MasterCount-1:0]   ptr_nxt_s;
    logic [MasterCount-1:0]   pick_s;
    logic [PayloadWidth-1:0]  payload_mux_s;
    logic                     valid_s;
    logic                     handshake_s;

    // First requester at or after the one-hot pointer, scanning upward with wrap.
    function automatic logic [MasterCount-1:0] rr_pick(
        input logic [MasterCount-1:0] req,
        input logic [MasterCount-1:0] ptr
    );
        logic [MasterCount-1:0] pick;
        logic                   found;
        logic [IDX_W-1:0]       idx;
        int                     base;
        int                     pos;
        pick  = {MasterCount{1'b0}};
        found = 1'b0;
        base  = 0;
        for (int i = 0; i < MasterCount; i++) begin
            base = ptr[i] ? i : base;
        end
        for (int k = 0; k < MasterCount; k++) begin
            pos       = (base + k) % MasterCount;
            idx       = IDX_W'(pos);
            pick[idx] = req[idx] & ~found;
            found     = found | req[idx];
        end
        return pick;
    endfunction

    assign pick_s = rr_pick(ARVALID_in, ptr_r);

    // Payload of the granted master; grant is one-hot so an AND-OR mux suffices.
    always_comb begin
        payload_mux_s = {PayloadWidth{1'b0}};
        for (int i = 0; i < MasterCount; i++) begin
            payload_mux_s = payload_mux_s |
                (ARpayload_in[i*PayloadWidth +: PayloadWidth] & {PayloadWidth{grant_r[i]}});
        end
    end

    assign valid_s     = (state_r == BUSY) & (|(ARVALID_in & grant_r));
    assign handshake_s = valid_s & ARREADY_in;

    // State, grant and priority pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            grant_r <= {MasterCount{1'b0}};
            ptr_r   <= {{(MasterCount-1){1'b0}}, 1'b1};
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Next-state logic: grant in IDLE, hold grant in BUSY until the handshake.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (|ARVALID_in) begin
                    grant_nxt_s = pick_s;
                    state_nxt_s = BUSY;
                end else begin
                    grant_nxt_s = {MasterCount{1'b0}};
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (handshake_s) begin
                    state_nxt_s = IDLE;
                    ptr_nxt_s   = {grant_r[MasterCount-2:0], grant_r[MasterCount-1]};
                    grant_nxt_s = {MasterCount{1'b0}};
                end else begin
                    state_nxt_s = BUSY;
                    grant_nxt_s = grant_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = {MasterCount{1'b0}};
                ptr_nxt_s   = {{(MasterCount-1){1'b0}}, 1'b1};
            end
        endcase
    end

    // Slave-facing outputs are driven only while a grant is held.
    always_comb begin
        if (state_r == BUSY) begin
            ARsel_out     = grant_r;
            ARpayload_out = payload_mux_s;
            ARVALID_out   = valid_s;
        end else begin
            ARsel_out     = {MasterCount{1'b0}};
            ARpayload_out = {PayloadWidth{1'b0}};
            ARVALID_out   = 1'b0;
        end
    end

endmodule

// File: tb/tb_par_arbiter_m2s.sv
// Directed bench for par_arbiter_m2s with two masters.
module tb_par_arbiter_m2s;

    localparam int M  = 2;
    localparam int PW = 49;

    logic            clk;
    logic            rst;
    logic [M-1:0]    ARVALID_in;
    logic [M*PW-1:0] ARpayload_in;
    logic            ARREADY_in;
    logic            ARVALID_out;
    logic [PW-1:0]   ARpayload_out;
    logic [M-1:0]    ARsel_out;

    logic [PW-1:0]   p0;
    logic [PW-1:0]   p1;
    logic [PW+M:0]   obs;
    logic [PW+M:0]   expv;

    int errors;
    int checks;

    par_arbiter_m2s #(.MasterCount(M), .PayloadWidth(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ARVALID_in   (ARVALID_in),
        .ARpayload_in (ARpayload_in),
        .ARREADY_in   (ARREADY_in),
        .ARVALID_out  (ARVALID_out),
        .ARpayload_out(ARpayload_out),
        .ARsel_out    (ARsel_out)
    );

    assign obs = {ARVALID_out, ARsel_out, ARpayload_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; ARVALID_in = 2'b11; ARREADY_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            expv = {1'b0, 2'b00, {PW{1'b0}}};
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, expv); end
        end
        rst = 1'b0;
        tick();
        expv = {1'b1, 2'b01, p0};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL reset_first_grant: got %h want %h", obs, expv); end
        ARVALID_in = 2'b01; ARREADY_in = 1'b1;
        tick();
        expv = {1'b0, 2'b00, {PW{1'b0}}};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL reset_release_idle: got %h want %h", obs, expv); end
        ARVALID_in = 2'b00;
        tick();
    endtask

    task automatic test_single();
        ARVALID_in = 2'b10; ARREADY_in = 1'b1;
        tick();
        expv = {1'b1, 2'b10, p1};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL single_grant: got %h want %h", obs, expv); end
        tick();
        expv = {1'b0, 2'b00, {PW{1'b0}}};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL single_idle: got %h want %h", obs, expv); end
        ARVALID_in = 2'b00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [M-1:0] exp_sel;
        ARVALID_in = 2'b11; ARREADY_in = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_sel = (g % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            expv = {1'b1, exp_sel, (g % 2 == 0) ? p0 : p1};
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL rr_grant[%0d]: got %h want %h", g, obs, expv); end
            tick();
            expv = {1'b0, 2'b00, {PW{1'b0}}};
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL rr_bubble[%0d]: got %h want %h", g, obs, expv); end
        end
        ARVALID_in = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        ARVALID_in = 2'b11; ARREADY_in = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            expv = {1'b1, 2'b01, p0};
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL bp_hold[%0d]: got %h want %h", i, obs, expv); end
            tick();
        end
        ARREADY_in = 1'b1;
        tick();
        expv = {1'b0, 2'b00, {PW{1'b0}}};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL bp_bubble: got %h want %h", obs, expv); end
        tick();
        expv = {1'b1, 2'b10, p1};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL bp_next_grant: got %h want %h", obs, expv); end
        tick();
        ARVALID_in = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        ARVALID_in = 2'b01; ARREADY_in = 1'b0;
        tick();
        expv = {1'b1, 2'b01, p0};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL rstmid_busy: got %h want %h", obs, expv); end
        rst = 1'b1;
        tick();
        expv = {1'b0, 2'b00, {PW{1'b0}}};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL rstmid_abandon: got %h want %h", obs, expv); end
        rst = 1'b0; ARVALID_in = 2'b10;
        tick();
        expv = {1'b1, 2'b10, p1};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL rstmid_regrant: got %h want %h", obs, expv); end
        ARREADY_in = 1'b1;
        tick();
        ARVALID_in = 2'b00;
        tick();
    endtask

    task automatic test_drop();
        // Pointer is back at master 0 here; master 1 also requests so a regrant would show up.
        ARVALID_in = 2'b11; ARREADY_in = 1'b0;
        tick();
        ARVALID_in = 2'b10; ARREADY_in = 1'b1;
        #1;
        expv = {1'b0, 2'b01, p0};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL drop_valid_low: got %h want %h", obs, expv); end
        tick();
        expv = {1'b0, 2'b01, p0};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL drop_grant_frozen: got %h want %h", obs, expv); end
        ARVALID_in = 2'b01;
        #1;
        expv = {1'b1, 2'b01, p0};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL drop_reassert: got %h want %h", obs, expv); end
        tick();
        expv = {1'b0, 2'b00, {PW{1'b0}}};
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL drop_handshake: got %h want %h", obs, expv); end
        ARVALID_in = 2'b00;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        p0 = 49'h0_AAAA_5555_0001;
        p1 = 49'h1_2345_6789_ABCD;
        ARpayload_in = {p1, p0};
        rst = 1'b1; ARVALID_in = 2'b00; ARREADY_in = 1'b0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
